// File: rtl/branch_predict_unit.sv
// Branch resolution for all six RV branch types, a 2-bit counter direction predictor and saturating stats.
// Latency: prediction and resolution are combinational; table and stats update at the next rising edge.
// Backpressure: none; one lookup and one resolution are accepted every cycle.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_LSB = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [XLEN-1:0]   f_pc,
    output logic              f_predict_taken,
    input  logic              e_valid,
    input  logic [XLEN-1:0]   e_pc,
    input  logic [2:0]        e_funct3,
    input  logic [XLEN-1:0]   e_rs1,
    input  logic [XLEN-1:0]   e_rs2,
    input  logic              e_predicted,
    output logic              e_taken,
    output logic              e_mispredict,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [1:0]        tbl_q [ENTRIES];
    logic [1:0]        tbl_d [ENTRIES];
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  e_idx;
    logic              cmp_eq, cmp_lt_s, cmp_lt_u;
    logic              legal, cond, upd;
    logic              unused_pc_bits;

    // Upper and lower PC bits never reach the index; aliasing is intended.
    assign f_idx = f_pc[IDX_LSB +: IDX_W];
    assign e_idx = e_pc[IDX_LSB +: IDX_W];
    assign unused_pc_bits = ^{f_pc, e_pc};

    always_comb begin
        cmp_eq   = (e_rs1 == e_rs2);
        cmp_lt_s = ($signed(e_rs1) < $signed(e_rs2));
        cmp_lt_u = (e_rs1 < e_rs2);
        legal    = 1'b1;
        cond     = 1'b0;
        case (e_funct3)
            3'b000:  cond = cmp_eq;
            3'b001:  cond = !cmp_eq;
            3'b100:  cond = cmp_lt_s;
            3'b101:  cond = !cmp_lt_s;
            3'b110:  cond = cmp_lt_u;
            3'b111:  cond = !cmp_lt_u;
            default: legal = 1'b0;
        endcase
    end

    assign upd             = e_valid & legal;
    assign e_taken         = upd & cond;
    assign e_mispredict    = upd & (cond != e_predicted);
    // Reads the pre-edge counter: a same-cycle update to this index is not bypassed.
    assign f_predict_taken = f_valid & tbl_q[f_idx][1];

    always_comb begin
        tbl_d = tbl_q;
        if (upd) begin
            if (cond) begin
                if (tbl_q[e_idx] != 2'b11) tbl_d[e_idx] = tbl_q[e_idx] + 2'b01;
            end else begin
                if (tbl_q[e_idx] != 2'b00) tbl_d[e_idx] = tbl_q[e_idx] - 2'b01;
            end
        end
    end

    // A clear wins over a coincident increment; that branch is simply not counted.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (clr_stats) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else if (upd) begin
            if (br_cnt_q != STAT_MAX) br_cnt_d = br_cnt_q + 1'b1;
            if (e_mispredict && (mp_cnt_q != STAT_MAX)) mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            tbl_q    <= tbl_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the execute-stage branch decision logic.
- Resolves all six RV32I/RV64I branch conditions from full operands. Unsigned compares are done natively, not derived from an ALU sign bit.
- Adds a direct-mapped table of 2-bit saturating counters for fetch-stage prediction, mispredict detection and saturating statistics counters.
- Sits between IF (prediction lookup) and EX (resolution/update) of the pipelined RISC-V core.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- ENTRIES, 64, number of prediction counters; power of 2, >=2.
- IDX_LSB, 2, lowest PC bit used for indexing.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- f_valid  in  1  fetch PC valid.
- f_pc  in  XLEN  fetch-stage PC.
- f_predict_taken  out  1  predicted direction for f_pc.
- e_valid  in  1  conditional branch present in EX this cycle.
- e_pc  in  XLEN  PC of the EX branch.
- e_funct3  in  3  branch type.
- e_rs1  in  XLEN  operand A.
- e_rs2  in  XLEN  operand B.
- e_predicted  in  1  prediction piped down from IF for this branch.
- e_taken  out  1  resolved direction.
- e_mispredict  out  1  resolved direction differs from e_predicted.
- clr_stats  in  1  synchronous clear of statistics.
- stat_branches  out  STAT_W  resolved branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

Behaviour:
- Index = pc[IDX_LSB+log2(ENTRIES)-1 : IDX_LSB]. The same function is used for f_pc and e_pc. Higher bits are ignored, so aliasing is permitted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- f_predict_taken = f_valid & table[f_idx][1]. Combinational, zero latency.
- Resolution is combinational from EX inputs:
  - 000 beq: rs1==rs2.
  - 001 bne: rs1!=rs2.
  - 100 blt: signed rs1<rs2.
  - 101 bge: signed rs1>=rs2.
  - 110 bltu: unsigned rs1<rs2.
  - 111 bgeu: unsigned rs1>=rs2.
  - 010 and 011 are illegal: e_taken=0, e_mispredict=0, no update, not counted.
- e_taken = 0 and e_mispredict = 0 whenever e_valid=0.
- e_mispredict = e_valid & legal & (e_taken != e_predicted).
- Update happens at the rising edge when e_valid & legal:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter -1, saturating at 00.
- Same-cycle read/write of one index: f_predict_taken reflects the pre-edge value. There is no bypass.
- Statistics:
  - On each legal resolved branch, stat_branches +1.
  - If mispredicted, stat_mispredicts +1 as well.
  - Both counters saturate at all-ones; they never wrap.
  - clr_stats=1 zeroes both counters at the edge and takes priority over a same-cycle increment; that event is lost.
  - clr_stats does not touch the prediction table.
- Reset (reset=0, asynchronous, at any time including mid-update):
  - All table entries go to 01.
  - Both statistics counters go to 0.
  - While reset is held, f_predict_taken=0. e_taken and e_mispredict still follow the combinational rules on their inputs.
  - After reset deasserts, the first edge may already update the table.
- No internal pipelining: the next-cycle lookup sees a completed update.

Test Plan:
- Reset check: pulse reset low mid-run after training several entries → f_predict_taken=0 for every index; stat_branches=0 and stat_mispredicts=0 immediately, without waiting for a clock edge.
- Training: three beq at e_pc=0x100 with rs1=rs2=5 and e_predicted taken from the table → counter 01→10→11→11. f_pc=0x100 predicts 0,1,1. stat_branches=3, stat_mispredicts=1.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x1 → blt taken=1, bge=0, bltu=0, bgeu=1. rs1=rs2 → bge=1, bgeu=1, blt=0, bltu=0.
- Aliasing and illegal funct3:
  - ENTRIES=64: train taken at 0x100 twice → f_pc=0x200 predicts 1 (shared index 0).
  - funct3=010 with e_valid=1 → no update, no count, e_mispredict=0.
- Read/write collision: f_pc=e_pc=0x40 while the 01 entry is updated taken → f_predict_taken=0 in that cycle, 1 in the next.
- Statistics edge cases:
  - STAT_W=4: 20 mispredicts → both counters hold 15.
  - clr_stats coincident with a mispredict → both read 0 the next cycle.
